id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameters: DATA_WIDTH=32 (datapath/PC width); REG_ADDR_BITS=5 (register address width; NUM_REGS=2**REG_ADDR_BITS); EXEC_BUS_WIDTH=6, MEM_BUS_WIDTH=3, WB_BUS_WIDTH=2 (control bus widths); CNT_WIDTH=16 (stall counter width).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-003 SHALL have upstream ports: in_valid  in  1  instruction valid; in_ready  out  1  stage accepts; inst_in  in  32  instruction word; next_pc_in  in  DATA_WIDTH  PC+4.
REQ-004 SHALL have writeback ports: wb_en  in  1  write enable; wb_addr  in  REG_ADDR_BITS  destination; wb_data  in  DATA_WIDTH  write data.
REQ-005 SHALL have hazard/control ports: ex_mem_read  in  1  EX-stage instruction is a load; ex_rt  in  REG_ADDR_BITS  load destination; flush  in  1  discard stage contents.
REQ-006 SHALL have downstream ports, all registered: out_valid  out  1; out_ready  in  1; execute_bus_out  out  EXEC_BUS_WIDTH; memory_bus_out  out  MEM_BUS_WIDTH; wb_bus_out  out  WB_BUS_WIDTH; reg_rs_data_out, reg_rt_data_out  out  DATA_WIDTH; add_reg_rs_out, add_reg_rt_out, add_reg_rd_out  out  REG_ADDR_BITS; inm_data_out  out  DATA_WIDTH; next_pc_out  out  DATA_WIDTH; stall_count  out  CNT_WIDTH.

Function
REQ-007 SHALL decode fields: opcode=inst_in[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], funct=[5:0]; control buses from the existing decoder module (combinational, opcode/funct).
REQ-008 SHALL hold a NUM_REGS x DATA_WIDTH register file; register 0 reads 0 always; write at posedge clk when wb_en=1 and wb_addr!=0.
REQ-009 SHALL bypass writeback: when wb_en=1, wb_addr!=0 and wb_addr equals rs (rt), rs (rt) read data = wb_data in the same cycle.
REQ-010 SHALL extend imm: zero-extend for opcodes 0x0C/0x0D/0x0E; imm<<16 with low bits zero for 0x0F; sign-extend otherwise; widths above 32 extend accordingly.
REQ-011 SHALL define advance = out_ready | ~out_valid; hazard = in_valid & ex_mem_read & (ex_rt!=0) & (ex_rt==rs | ex_rt==rt).
REQ-012 SHALL drive in_ready = flush | (advance & ~hazard), combinationally.
REQ-013 SHALL, on clock edge with flush=1 (highest priority): out_valid<=0, all three control buses<=0; input discarded; other outputs don't-care-hold.
REQ-014 SHALL, else if advance & hazard: insert bubble, out_valid<=1, control buses<=0, register/imm/pc outputs hold; instruction remains at input.
REQ-015 SHALL, else if advance & in_valid: load all output registers from the decoded instruction, out_valid<=1; latency one cycle from acceptance.
REQ-016 SHALL, else if advance & ~in_valid: out_valid<=0, control buses<=0.
REQ-017 SHALL, when ~advance and ~flush, hold every output register unchanged.
REQ-018 SHALL increment stall_count by 1 on each edge where hazard & advance & ~flush, saturating at all-ones.
REQ-019 SHALL perform register-file write independently of flush, stall and backpressure.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously clear all register-file entries, every output register, out_valid and stall_count to 0.
REQ-021 SHALL resume normal operation at the first rising clk edge after rst_n returns high; a reset mid-stall discards the held instruction state.

Verification
REQ-022 Write/bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF while decoding rs=5 -> next cycle reg_rs_data_out=0xDEADBEEF; wb_addr=0 write -> reads 0.
REQ-023 Immediate: imm=0x8001, opcode 0x08 -> 0xFFFF8001; opcode 0x0D -> 0x00008001; opcode 0x0F -> 0x80010000.
REQ-024 Load-use: ex_mem_read=1, ex_rt=3, inst rs=3 -> in_ready=0, one bubble (out_valid=1, buses 0), stall_count=1; ex_mem_read=0 next cycle -> instruction issued.
REQ-025 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> outputs stable, in_ready=0; out_ready=1 -> next instruction loaded.
REQ-026 Flush: flush=1 with in_valid=1 -> in_ready=1, next cycle out_valid=0, buses 0.
REQ-027 Reset: rst_n low mid-operation -> outputs, stall_count, register file 0 immediately, no clock required.

Source files
------------

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction decode stage of a 5-stage MIPS-style pipeline.
//
// Decodes the incoming 32-bit instruction. Reads two operands from the
// register file, with same-cycle bypass of the writeback port. Extends the
// 16-bit immediate. Registers everything into the ID/EX output bank behind
// a valid/ready handshake. A load-use hazard against the EX stage inserts a
// bubble and holds the instruction at the input until the hazard clears.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   inst_in             instruction word
//   next_pc_in          PC+4 of the instruction
//   wb_en/wb_addr/wb_data   register-file write port (from WB stage)
//   ex_mem_read, ex_rt  EX-stage load and its destination register
//   flush               discard the instruction at the input and the output
//   out_valid/out_ready downstream handshake
//   execute_bus_out     {reg_dst, alu_src, alu_op[3:0]}
//   memory_bus_out      {mem_read, mem_write, branch}
//   wb_bus_out          {reg_write, mem_to_reg}
//   reg_rs/rt_data_out  operand values
//   add_reg_rs/rt/rd_out  register addresses
//   inm_data_out        extended immediate
//   next_pc_out         PC+4 passed down the pipe
//   stall_count         saturating count of load-use bubbles inserted
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_BITS  = 5,
  parameter int EXEC_BUS_WIDTH = 6,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // upstream
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               inst_in,
  input  logic [DATA_WIDTH-1:0]     next_pc_in,
  // writeback
  input  logic                      wb_en,
  input  logic [REG_ADDR_BITS-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  // hazard / control
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_BITS-1:0]  ex_rt,
  input  logic                      flush,
  // downstream
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXEC_BUS_WIDTH-1:0] execute_bus_out,
  output logic [MEM_BUS_WIDTH-1:0]  memory_bus_out,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
  output logic [DATA_WIDTH-1:0]     reg_rs_data_out,
  output logic [DATA_WIDTH-1:0]     reg_rt_data_out,
  output logic [REG_ADDR_BITS-1:0]  add_reg_rs_out,
  output logic [REG_ADDR_BITS-1:0]  add_reg_rt_out,
  output logic [REG_ADDR_BITS-1:0]  add_reg_rd_out,
  output logic [DATA_WIDTH-1:0]     inm_data_out,
  output logic [DATA_WIDTH-1:0]     next_pc_out,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  localparam int NUM_REGS = 2 ** REG_ADDR_BITS;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // -------------------------------------------------------------------------
  // Field extraction
  // -------------------------------------------------------------------------
  logic [5:0]               opcode;
  logic [5:0]               funct;
  logic [15:0]              imm;
  logic [REG_ADDR_BITS-1:0] rs;
  logic [REG_ADDR_BITS-1:0] rt;
  logic [REG_ADDR_BITS-1:0] rd;

  assign opcode = inst_in[31:26];
  assign funct  = inst_in[5:0];
  assign imm    = inst_in[15:0];
  assign rs     = REG_ADDR_BITS'(inst_in[25:21]);
  assign rt     = REG_ADDR_BITS'(inst_in[20:16]);
  assign rd     = REG_ADDR_BITS'(inst_in[15:11]);

  // -------------------------------------------------------------------------
  // Control decoder
  // -------------------------------------------------------------------------
  logic       rtype_known;
  logic [3:0] rtype_alu;
  logic [5:0] exec_dec;
  logic [2:0] mem_dec;
  logic [1:0] wb_dec;

  always_comb begin
    rtype_known = 1'b1;
    rtype_alu   = ALU_ADD;
    case (funct)
      FN_ADD:  rtype_alu = ALU_ADD;
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_XOR:  rtype_alu = ALU_XOR;
      FN_SLT:  rtype_alu = ALU_SLT;
      default: rtype_known = 1'b0;
    endcase
  end

  // Unknown encodings decode to an all-zero control word, i.e. a NOP.
  always_comb begin
    exec_dec = 6'b0;
    mem_dec  = 3'b0;
    wb_dec   = 2'b0;
    case (opcode)
      OP_RTYPE: begin
        if (rtype_known) begin
          exec_dec = {1'b1, 1'b0, rtype_alu};
          wb_dec   = 2'b10;
        end
      end
      OP_ADDI: begin exec_dec = {2'b01, ALU_ADD}; wb_dec = 2'b10; end
      OP_SLTI: begin exec_dec = {2'b01, ALU_SLT}; wb_dec = 2'b10; end
      OP_ANDI: begin exec_dec = {2'b01, ALU_AND}; wb_dec = 2'b10; end
      OP_ORI:  begin exec_dec = {2'b01, ALU_OR};  wb_dec = 2'b10; end
      OP_XORI: begin exec_dec = {2'b01, ALU_XOR}; wb_dec = 2'b10; end
      OP_LUI:  begin exec_dec = {2'b01, ALU_LUI}; wb_dec = 2'b10; end
      OP_LW: begin
        exec_dec = {2'b01, ALU_ADD};
        mem_dec  = 3'b100;
        wb_dec   = 2'b11;
      end
      OP_SW: begin
        exec_dec = {2'b01, ALU_ADD};
        mem_dec  = 3'b010;
      end
      OP_BEQ: begin
        exec_dec = {2'b00, ALU_SUB};
        mem_dec  = 3'b001;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Immediate extension. Size casts of signed values sign-extend, so the
  // same expressions stay correct for DATA_WIDTH above 32.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] imm_ext;

  always_comb begin
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = DATA_WIDTH'(imm);
      OP_LUI:                   imm_ext = DATA_WIDTH'($signed({imm, 16'h0000}));
      default:                  imm_ext = DATA_WIDTH'($signed(imm));
    endcase
  end

  // -------------------------------------------------------------------------
  // Register file. Entry 0 is never written, so it stays at its reset
  // value; the read path also forces it to zero explicitly.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rf_reg [NUM_REGS];
  logic                  wb_write;

  assign wb_write = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_reg[i] <= '0;
      end
    end else if (wb_write) begin
      rf_reg[wb_addr] <= wb_data;
    end
  end

  // Same-cycle bypass: a write landing this edge is visible to the decode
  // happening in the same cycle.
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;

  always_comb begin
    if (wb_write && (wb_addr == rs)) rs_data = wb_data;
    else if (rs == '0)               rs_data = '0;
    else                             rs_data = rf_reg[rs];

    if (wb_write && (wb_addr == rt)) rt_data = wb_data;
    else if (rt == '0)               rt_data = '0;
    else                             rt_data = rf_reg[rt];
  end

  // -------------------------------------------------------------------------
  // Handshake and load-use hazard
  // -------------------------------------------------------------------------
  logic advance;
  logic hazard;

  assign advance  = out_ready | ~out_valid;
  assign hazard   = in_valid & ex_mem_read & (ex_rt != '0) &
                    ((ex_rt == rs) | (ex_rt == rt));
  // A flush drops the input, so it is always "accepted".
  assign in_ready = flush | (advance & ~hazard);

  // -------------------------------------------------------------------------
  // ID/EX output bank
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      execute_bus_out <= '0;
      memory_bus_out  <= '0;
      wb_bus_out      <= '0;
      reg_rs_data_out <= '0;
      reg_rt_data_out <= '0;
      add_reg_rs_out  <= '0;
      add_reg_rt_out  <= '0;
      add_reg_rd_out  <= '0;
      inm_data_out    <= '0;
      next_pc_out     <= '0;
    end else if (flush) begin
      out_valid       <= 1'b0;
      execute_bus_out <= '0;
      memory_bus_out  <= '0;
      wb_bus_out      <= '0;
    end else if (advance) begin
      if (hazard) begin
        // Bubble: a valid NOP; the datapath fields keep their old values.
        out_valid       <= 1'b1;
        execute_bus_out <= '0;
        memory_bus_out  <= '0;
        wb_bus_out      <= '0;
      end else if (in_valid) begin
        out_valid       <= 1'b1;
        execute_bus_out <= EXEC_BUS_WIDTH'(exec_dec);
        memory_bus_out  <= MEM_BUS_WIDTH'(mem_dec);
        wb_bus_out      <= WB_BUS_WIDTH'(wb_dec);
        reg_rs_data_out <= rs_data;
        reg_rt_data_out <= rt_data;
        add_reg_rs_out  <= rs;
        add_reg_rt_out  <= rt;
        add_reg_rd_out  <= rd;
        inm_data_out    <= imm_ext;
        next_pc_out     <= next_pc_in;
      end else begin
        out_valid       <= 1'b0;
        execute_bus_out <= '0;
        memory_bus_out  <= '0;
        wb_bus_out      <= '0;
      end
    end
  end

  // Bubble counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard && advance && !flush && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
